// File: rtl/cjb_alu_status_reg_v.sv
// ALU result/status staging: a 2-entry in-order buffer of {flag_we, cnvz, result}
// that feeds register-file writeback and commits condition codes only when an
// entry leaves the buffer.
module cjb_alu_status_reg_v (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] unit_result_i,
    input  logic [3:0] unit_cnvz_i,
    input  logic [3:0] flag_we_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic [7:0] out_result_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    input  logic       clear_flags_i,
    output logic [3:0] status_cnvz_o,
    output logic [1:0] occupancy_o
);

    localparam int unsigned RES_W   = 8;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned ENTRY_W = RES_W + FLAG_W + FLAG_W;
    localparam int unsigned OCC_W   = 2;
    localparam logic [OCC_W-1:0] OCC_FULL = 2'd2;

    // Entry layout: {flag_we[15:12], cnvz[11:8], result[7:0]}
    logic [ENTRY_W-1:0] mem_q [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [FLAG_W-1:0]  status_q, status_d;
    logic [RES_W-1:0]   out_result_q, out_result_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               push, pop;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [FLAG_W-1:0]  head_we, head_cnvz;

    assign in_entry   = {flag_we_i, unit_cnvz_i, unit_result_i};
    assign head_entry = mem_q[rd_ptr_q];
    assign head_we    = head_entry[ENTRY_W-1 -: FLAG_W];
    assign head_cnvz  = head_entry[RES_W +: FLAG_W];

    // Handshakes qualified by the registered ready/valid so refused requests are no-ops
    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_q & out_ready_i;

    // Next-state: pointers, occupancy, registered head view and condition codes
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        status_d     = status_q;
        out_result_d = '0;
        out_valid_d  = 1'b0;
        in_ready_d   = 1'b1;

        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

        // Head next cycle is either the entry being written now or a stored one
        if (occ_d != '0) begin
            out_valid_d = 1'b1;
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                out_result_d = unit_result_i;
            end else begin
                out_result_d = mem_q[rd_ptr_d][RES_W-1:0];
            end
        end
        in_ready_d = (occ_d != OCC_FULL);

        // Clear wins over a same-cycle commit; the pop itself still happens
        if (clear_flags_i) begin
            status_d = '0;
        end else if (pop) begin
            status_d = (status_q & ~head_we) | (head_cnvz & head_we);
        end
    end

    // Control and status state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            occ_q        <= '0;
            status_q     <= '0;
            out_result_q <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            status_q     <= status_d;
            out_result_q <= out_result_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Entry storage, written at the tail on an accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_result_o  = out_result_q;
    assign out_valid_o   = out_valid_q;
    assign status_cnvz_o = status_q;
    assign occupancy_o   = occ_q;

endmodule

// File: tb/tb_cjb_alu_status_reg_v.sv
// Directed bench for cjb_alu_status_reg_v with hand-computed expectations.
module tb_cjb_alu_status_reg_v;

    logic       clk;
    logic       rst_n;
    logic [7:0] unit_result_i;
    logic [3:0] unit_cnvz_i;
    logic [3:0] flag_we_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] out_result_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       clear_flags_i;
    logic [3:0] status_cnvz_o;
    logic [1:0] occupancy_o;

    int total = 0;
    int bad   = 0;

    cjb_alu_status_reg_v dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .unit_result_i (unit_result_i),
        .unit_cnvz_i   (unit_cnvz_i),
        .flag_we_i     (flag_we_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .out_result_o  (out_result_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .clear_flags_i (clear_flags_i),
        .status_cnvz_o (status_cnvz_o),
        .occupancy_o   (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic [3:0] c, input logic [3:0] we);
        in_valid_i    = v;
        unit_result_i = r;
        unit_cnvz_i   = c;
        flag_we_i     = we;
    endtask

    initial begin
        rst_n         = 1'b0;
        out_ready_i   = 1'b0;
        clear_flags_i = 1'b0;
        drive(1'b0, 8'h00, 4'h0, 4'h0);
        step();
        step();
        chk("rst_in_ready",  8'(in_ready_o),    8'd1);
        chk("rst_out_valid", 8'(out_valid_o),   8'd0);
        chk("rst_out_result", out_result_o,     8'h00);
        chk("rst_status",    8'(status_cnvz_o), 8'h0);
        chk("rst_occ",       8'(occupancy_o),   8'd0);
        rst_n = 1'b1;

        // Basic push then pop with full flag write
        out_ready_i = 1'b1;
        drive(1'b1, 8'hAA, 4'b0100, 4'b1111);
        step();
        chk("b_out_result", out_result_o,     8'hAA);
        chk("b_out_valid",  8'(out_valid_o),   8'd1);
        chk("b_occ",        8'(occupancy_o),   8'd1);
        chk("b_no_commit_on_push", 8'(status_cnvz_o), 8'h0);
        drive(1'b0, 8'h00, 4'h0, 4'h0);
        step();
        chk("b_status", 8'(status_cnvz_o), 8'b0100);
        chk("b_occ0",   8'(occupancy_o),   8'd0);
        chk("b_empty_result", out_result_o, 8'h00);
        chk("b_empty_valid",  8'(out_valid_o), 8'd0);

        // Partial flag write; stalled head must not expose its flags
        out_ready_i = 1'b0;
        drive(1'b1, 8'h00, 4'b0001, 4'b0001);
        step();
        drive(1'b0, 8'h00, 4'h0, 4'h0);
        chk("p_stalled_status", 8'(status_cnvz_o), 8'b0100);
        out_ready_i = 1'b1;
        step();
        chk("p_status", 8'(status_cnvz_o), 8'b0101);

        // WE=0 passes result without touching flags
        drive(1'b1, 8'h33, 4'b1010, 4'b0000);
        step();
        drive(1'b0, 8'h00, 4'h0, 4'h0);
        chk("w0_result", out_result_o, 8'h33);
        step();
        chk("w0_status", 8'(status_cnvz_o), 8'b0101);

        // Fill to full, refused third push, then ordered drain
        out_ready_i = 1'b0;
        drive(1'b1, 8'h55, 4'b1000, 4'b1000);
        step();
        drive(1'b1, 8'hFF, 4'b1111, 4'b0000);
        step();
        chk("f_occ2",     8'(occupancy_o), 8'd2);
        chk("f_in_ready", 8'(in_ready_o),  8'd0);
        drive(1'b1, 8'h00, 4'b0010, 4'b1111);
        step();
        chk("f_refused_occ",  8'(occupancy_o), 8'd2);
        chk("f_head",         out_result_o,    8'h55);
        chk("f_refused_stat", 8'(status_cnvz_o), 8'b0101);
        drive(1'b0, 8'h00, 4'h0, 4'h0);
        out_ready_i = 1'b1;
        step();
        chk("f_pop1_result", out_result_o,     8'hFF);
        chk("f_pop1_occ",    8'(occupancy_o),   8'd1);
        chk("f_pop1_status", 8'(status_cnvz_o), 8'b1101);
        chk("f_pop1_ready",  8'(in_ready_o),    8'd1);
        step();
        chk("f_pop2_occ",    8'(occupancy_o),   8'd0);
        chk("f_pop2_result", out_result_o,      8'h00);
        chk("f_pop2_status", 8'(status_cnvz_o), 8'b1101);

        // Pop while empty is ignored
        step();
        chk("e_pop_occ",    8'(occupancy_o),   8'd0);
        chk("e_pop_status", 8'(status_cnvz_o), 8'b1101);

        // Full with simultaneous pop and offered push: no push, occupancy drops to 1
        out_ready_i = 1'b0;
        drive(1'b1, 8'hA1, 4'h0, 4'h0);
        step();
        drive(1'b1, 8'hA2, 4'h0, 4'h0);
        step();
        drive(1'b1, 8'h77, 4'hF, 4'hF);
        out_ready_i = 1'b1;
        step();
        chk("fp_occ",  8'(occupancy_o), 8'd1);
        chk("fp_head", out_result_o,    8'hA2);

        // Occupancy 1: push+pop with clear -> occupancy 1, new head, flags cleared
        drive(1'b1, 8'h11, 4'b0010, 4'b1111);
        clear_flags_i = 1'b1;
        step();
        clear_flags_i = 1'b0;
        chk("c_occ",    8'(occupancy_o),   8'd1);
        chk("c_head",   out_result_o,      8'h11);
        chk("c_status", 8'(status_cnvz_o), 8'h0);

        // Fill to 2 with flag-writing entries, then async reset between edges
        out_ready_i = 1'b0;
        drive(1'b1, 8'h22, 4'b1111, 4'b1111);
        step();
        drive(1'b0, 8'h00, 4'h0, 4'h0);
        chk("r_pre_occ", 8'(occupancy_o), 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_valid",  8'(out_valid_o),   8'd0);
        chk("r_async_occ",    8'(occupancy_o),   8'd0);
        chk("r_async_status", 8'(status_cnvz_o), 8'h0);
        chk("r_async_result", out_result_o,      8'h00);
        chk("r_async_ready",  8'(in_ready_o),    8'd1);
        rst_n = 1'b1;

        // First edge after reset release accepts a push
        drive(1'b1, 8'h99, 4'h0, 4'h0);
        step();
        drive(1'b0, 8'h00, 4'h0, 4'h0);
        chk("r_first_push", out_result_o,      8'h99);
        chk("r_first_occ",  8'(occupancy_o),   8'd1);
        chk("r_no_commit",  8'(status_cnvz_o), 8'h0);
        out_ready_i = 1'b1;
        step();
        chk("r_drain_occ", 8'(occupancy_o), 8'd0);
        chk("r_drain_status", 8'(status_cnvz_o), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
